// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared encodings for the 16-bit CPU control unit:
//     - FSM state encoding (state_t + S_* constants)
//     - opcode / opcode-extension constants
//     - ALU operation codes driven on alu_op
//     - pc_sel / wb_sel encodings
//     - branch condition codes (carried in the Rdest field)
//     - decode_t and decode_instr(), the pure decode of one instruction
//
//   Opcode map (instr[15:12]):
//     0000 R-type (ALU op in instr[7:4])   1000 LSH group
//     0001 ANDI   0011 ORI   1110 XORI      1001 SUBI  1010 SUBCI  1011 CMPI
//     0100 special (LOAD/STOR/JAL/Jcond)    1100 Bcond
//     0101 ADDI   0110 ADDUI 0111 ADDCI     1101 MOVI
//     1111 LUI    0010 unassigned (executes as NOP)
//   Immediate ALU opcodes reuse the R-type extension value of the same
//   operation, so alu_op is simply OpCode for immediates and ImmHi_OpExt for
//   R-type.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // FSM state encoding
  typedef logic [3:0] state_t;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_LATCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC    = 4'd3;
  localparam logic [3:0] S_LD_ADDR = 4'd4;
  localparam logic [3:0] S_LD_WB   = 4'd5;
  localparam logic [3:0] S_ST      = 4'd6;
  localparam logic [3:0] S_BRANCH  = 4'd7;
  localparam logic [3:0] S_JAL     = 4'd8;
  localparam logic [3:0] S_NOP     = 4'd9;

  // Major opcodes (instr[15:12])
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_ADDUI   = 4'b0110;
  localparam logic [3:0] OP_ADDCI   = 4'b0111;
  localparam logic [3:0] OP_LSH     = 4'b1000;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_SUBCI   = 4'b1010;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;
  localparam logic [3:0] OP_XORI    = 4'b1110;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  // Extensions (instr[7:4]) inside the special group
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  // Extension inside the LSH group selecting the register shift amount
  localparam logic [3:0] EXT_LSH_REG = 4'b0100;

  // ALU operation codes presented on alu_op
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_ADDU = 4'b0110;
  localparam logic [3:0] ALU_ADDC = 4'b0111;
  localparam logic [3:0] ALU_LSH  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_SUBC = 4'b1010;
  localparam logic [3:0] ALU_CMP  = 4'b1011;
  localparam logic [3:0] ALU_MOV  = 4'b1101;
  localparam logic [3:0] ALU_XOR  = 4'b1110;

  // PC next-value select
  localparam logic [1:0] PC_SEL_INC  = 2'b00;  // PC + 1
  localparam logic [1:0] PC_SEL_DISP = 2'b01;  // PC + sext(disp)
  localparam logic [1:0] PC_SEL_REG  = 2'b10;  // reg Rsrc

  // Register file write-back select
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;  // PC + 1
  localparam logic [1:0] WB_SEL_LUI  = 2'b11;  // {imm8, 8'h00}

  // Condition codes (Rdest field of Bcond/Jcond)
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  // Instruction class chosen in DECODE; drives the dispatch
  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_LUI   = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STOR  = 3'd4,
    CLS_BCOND = 3'd5,
    CLS_JCOND = 3'd6,
    CLS_JAL   = 3'd7
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   alu_op;
    logic         alu_b_sel;  // 1: immediate operand
    logic         imm_sext;   // 1: sign-extend imm8
    logic         wr_rdest;   // ALU result written back
    logic         upd_psr;    // ALU flags captured
  } decode_t;

  // Operation codes the ALU implements through the generic R/I path
  function automatic logic is_alu_code(input logic [3:0] code);
    logic hit;
    case (code)
      ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_ADDU, ALU_ADDC,
      ALU_SUB, ALU_SUBC, ALU_CMP, ALU_MOV: hit = 1'b1;
      default:                             hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Logical immediates take a zero-extended imm8
  function automatic logic is_logic_code(input logic [3:0] code);
    return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_XOR);
  endfunction

  // Arithmetic ops whose carry/flag results land in the PSR
  function automatic logic sets_flags(input logic [3:0] code);
    return (code == ALU_ADD) || (code == ALU_ADDC) || (code == ALU_SUB) ||
           (code == ALU_SUBC) || (code == ALU_CMP);
  endfunction

  function automatic decode_t decode_instr(input logic [3:0] op,
                                           input logic [3:0] ext);
    decode_t d;
    d     = '0;
    d.cls = CLS_NOP;
    case (op)
      OP_RTYPE: begin
        if (is_alu_code(ext)) begin
          d.cls    = CLS_ALU;
          d.alu_op = ext;
        end
      end
      OP_SPECIAL: begin
        case (ext)
          EXT_LOAD:  d.cls = CLS_LOAD;
          EXT_STOR:  d.cls = CLS_STOR;
          EXT_JAL:   d.cls = CLS_JAL;
          EXT_JCOND: d.cls = CLS_JCOND;
          default:   d.cls = CLS_NOP;
        endcase
      end
      OP_LSH: begin
        if (ext == EXT_LSH_REG) begin
          d.cls    = CLS_ALU;
          d.alu_op = ALU_LSH;
        end else if (ext[3:1] == 3'b000) begin
          // ext[0] is the sign bit of the 5-bit shift amount
          d.cls       = CLS_ALU;
          d.alu_op    = ALU_LSH;
          d.alu_b_sel = 1'b1;
          d.imm_sext  = 1'b1;
        end
      end
      OP_BCOND: d.cls = CLS_BCOND;
      OP_LUI:   d.cls = CLS_LUI;
      default: begin
        if (is_alu_code(op)) begin
          d.cls       = CLS_ALU;
          d.alu_op    = op;
          d.alu_b_sel = 1'b1;
          d.imm_sext  = !is_logic_code(op);
        end
      end
    endcase
    if (d.cls == CLS_ALU) begin
      d.wr_rdest = (d.alu_op != ALU_CMP);
      d.upd_psr  = sets_flags(d.alu_op);
    end
    return d;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
//   Combinational branch-condition evaluator.
//   Ports:
//     cond [3:0] : condition code (Rdest field of Bcond/Jcond)
//     psr  [4:0] : processor flags {C, L, F, Z, N}
//     take       : 1 when the condition holds
// ---------------------------------------------------------------------------
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] psr,
  output logic       take
);

  logic flag_c;
  logic flag_l;
  logic flag_f;
  logic flag_z;
  logic flag_n;

  assign {flag_c, flag_l, flag_f, flag_z, flag_n} = psr;

  always_comb begin
    take = 1'b0;
    case (cond)
      CC_EQ:   take = flag_z;
      CC_NE:   take = !flag_z;
      CC_CS:   take = flag_c;
      CC_CC:   take = !flag_c;
      CC_HI:   take = flag_l;
      CC_LS:   take = !flag_l;
      CC_GT:   take = flag_n;
      CC_LE:   take = !flag_n;
      CC_FS:   take = flag_f;
      CC_FC:   take = !flag_f;
      CC_LO:   take = !flag_l && !flag_z;
      CC_HS:   take = flag_l || flag_z;
      CC_LT:   take = !flag_n && !flag_z;
      CC_GE:   take = flag_n || flag_z;
      CC_UC:   take = 1'b1;
      CC_NV:   take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
//   Multi-cycle Moore control unit for the 16-bit CPU. One instruction per
//   pass: FETCH -> LATCH -> DECODE -> execute state(s) -> FETCH.
//   All outputs are combinational from the state register, the instruction
//   fields held in the datapath's instr register, and the PSR.
//
//   Ports:
//     clk          : system clock, rising edge
//     reset_n      : asynchronous active-low reset (forces FETCH)
//     OpCode       : instr[15:12]
//     Rdest        : instr[11:8], condition code for Bcond/Jcond
//     ImmHi_OpExt  : instr[7:4]
//     ImmLo_Rsrc   : instr[3:0]
//     psr          : flags {C, L, F, Z, N}
//     instr_en     : latch mem_rd_data into instr register
//     pc_en        : load PC
//     pc_sel       : 00 PC+1, 01 PC+sext(disp), 10 reg Rsrc
//     mem_addr_sel : 0 PC, 1 reg Rsrc
//     mem_wr_en    : memory write strobe
//     reg_wr_en    : register file write to Rdest
//     wb_sel       : 00 ALU, 01 mem_rd_data, 10 PC+1, 11 {imm8,8'h00}
//     alu_b_sel    : 0 reg Rsrc, 1 immediate
//     imm_sext     : 1 sign-extend imm8, 0 zero-extend
//     alu_op       : ALU operation (cpu_ctrl_pkg ALU_*)
//     psr_en       : capture ALU flags into PSR
// ---------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_DISP_W = 8
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] OpCode,
  input  logic [3:0] Rdest,
  input  logic [3:0] ImmHi_OpExt,
  input  logic [3:0] ImmLo_Rsrc,
  input  logic [4:0] psr,
  output logic       instr_en,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       mem_addr_sel,
  output logic       mem_wr_en,
  output logic       reg_wr_en,
  output logic [1:0] wb_sel,
  output logic       alu_b_sel,
  output logic       imm_sext,
  output logic [3:0] alu_op,
  output logic       psr_en
);

  state_t  state_reg;
  state_t  state_next;
  decode_t dec;
  logic    cond_take;

  // The branch displacement {ImmHi_OpExt, ImmLo_Rsrc} is sign-extended and
  // added by the datapath; control only needs to know which PC source to
  // pick. The sink below ties the field width to PC_DISP_W.
  logic [PC_DISP_W-1:0] unused_branch_disp;
  assign unused_branch_disp = {ImmHi_OpExt, ImmLo_Rsrc};

  // Decode is purely a function of the held fields, so it is equally valid
  // in DECODE and in every execute state that follows.
  always_comb begin
    dec = decode_instr(OpCode, ImmHi_OpExt);
  end

  // psr only matters in BRANCH; a flag write in EXEC lands on the edge that
  // leaves EXEC, so the following instruction's BRANCH sees it.
  cond_eval u_cond_eval (
    .cond (Rdest),
    .psr  (psr),
    .take (cond_take)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_LATCH;
      S_LATCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          CLS_ALU:   state_next = S_EXEC;
          CLS_LUI:   state_next = S_EXEC;
          CLS_LOAD:  state_next = S_LD_ADDR;
          CLS_STOR:  state_next = S_ST;
          CLS_BCOND: state_next = S_BRANCH;
          CLS_JCOND: state_next = S_BRANCH;
          CLS_JAL:   state_next = S_JAL;
          CLS_NOP:   state_next = S_NOP;
          default:   state_next = S_NOP;
        endcase
      end
      S_LD_ADDR: state_next = S_LD_WB;
      // Every terminal state returns to FETCH; listed for readability.
      S_EXEC, S_LD_WB, S_ST, S_BRANCH, S_JAL, S_NOP: state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    instr_en     = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_SEL_INC;
    mem_addr_sel = 1'b0;
    mem_wr_en    = 1'b0;
    reg_wr_en    = 1'b0;
    wb_sel       = WB_SEL_ALU;
    alu_b_sel    = 1'b0;
    imm_sext     = 1'b0;
    alu_op       = ALU_NONE;
    psr_en       = 1'b0;

    case (state_reg)
      // FETCH presents PC as the address; the synchronous memory returns
      // the word one cycle later, which LATCH captures.
      S_FETCH: mem_addr_sel = 1'b0;
      S_LATCH: instr_en = 1'b1;
      S_DECODE: begin
      end
      S_EXEC: begin
        pc_en  = 1'b1;
        pc_sel = PC_SEL_INC;
        if (dec.cls == CLS_LUI) begin
          wb_sel    = WB_SEL_LUI;
          reg_wr_en = 1'b1;
        end else begin
          wb_sel    = WB_SEL_ALU;
          alu_op    = dec.alu_op;
          alu_b_sel = dec.alu_b_sel;
          imm_sext  = dec.imm_sext;
          reg_wr_en = dec.wr_rdest;
          psr_en    = dec.upd_psr;
        end
      end
      S_LD_ADDR: mem_addr_sel = 1'b1;
      S_LD_WB: begin
        wb_sel    = WB_SEL_MEM;
        reg_wr_en = 1'b1;
        pc_en     = 1'b1;
        pc_sel    = PC_SEL_INC;
      end
      // Single-cycle state, so the write strobe cannot stretch; an async
      // reset drops it in the same cycle.
      S_ST: begin
        mem_addr_sel = 1'b1;
        mem_wr_en    = 1'b1;
        pc_en        = 1'b1;
        pc_sel       = PC_SEL_INC;
      end
      S_BRANCH: begin
        pc_en = 1'b1;
        if (cond_take) begin
          pc_sel = (dec.cls == CLS_BCOND) ? PC_SEL_DISP : PC_SEL_REG;
        end else begin
          pc_sel = PC_SEL_INC;
        end
      end
      // Link write and jump share one edge: the PC reads reg Rsrc before
      // the register file commits PC+1, even when Rdest == Rsrc.
      S_JAL: begin
        wb_sel    = WB_SEL_LINK;
        reg_wr_en = 1'b1;
        pc_en     = 1'b1;
        pc_sel    = PC_SEL_REG;
      end
      S_NOP: begin
        pc_en  = 1'b1;
        pc_sel = PC_SEL_INC;
      end
      default: begin
      end
    endcase
  end

endmodule
